rv_iopmp_err_capture: RTL
=========================

// Module: rv_iopmp_err_capture
// PURPOSE
//  Error-record stage between rv_iopmp_transaction_logic instances and the IOPMP register map.
//  Arbitrates per-instance violation reports and latches one error record until software clears it.
//  Counts violations dropped while a record is held and drives the wired-signalled interrupt (WSI).
//  The regmap exposes the record as ERR_REQINFO/ERR_REQADDR/ERR_REQID and forwards wsi_o to wsi_wire_o.
// PARAMETERS
//  NUMBER_TL_INSTANCES  1   number of transaction-logic instances reporting errors
//  ADDR_WIDTH           64  width of violating address
//  SID_WIDTH            1   width of source ID
//  LOST_CNT_WIDTH       8   width of saturating dropped-error counter
// PORTS
//  clk_i          in   1                         clock
//  rst_ni         in   1                         asynchronous reset, active low
//  err_valid_i    in   NUMBER_TL_INSTANCES       per-instance single-cycle violation pulse
//  err_addr_i     in   NUMBER_TL_INSTANCES*ADDR_WIDTH  violating address, per instance
//  err_sid_i      in   NUMBER_TL_INSTANCES*SID_WIDTH   violating SID, per instance
//  err_ttype_i    in   NUMBER_TL_INSTANCES*2     access_t of violating request (read/write)
//  err_etype_i    in   NUMBER_TL_INSTANCES*3     err_type_t code (no-hit, perm, partial-hit, ...)
//  intr_en_i      in   1                         global interrupt enable from regmap
//  clear_i        in   1                         one-cycle SW write-1-to-clear of the record
//  rec_valid_o    out  1                         record held (ERR_REQINFO.ip)
//  rec_addr_o     out  ADDR_WIDTH                captured address
//  rec_sid_o      out  SID_WIDTH                 captured SID
//  rec_ttype_o    out  2                         captured access type
//  rec_etype_o    out  3                         captured error type
//  rec_inst_o     out  max(1,clog2(NUMBER_TL_INSTANCES))  reporting instance index
//  lost_cnt_o     out  LOST_CNT_WIDTH            dropped violations since last clear, saturating
//  wsi_o          out  1                         interrupt level
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; round-robin pointer 0.
//  - FSM IDLE -> HELD on any err_valid_i bit; HELD -> IDLE on clear_i.
//  - Arbitration: round-robin among asserted err_valid_i, starting at pointer; pointer moves to
//    winner+1 (mod N) on every capture. N=1: winner always 0.
//  - Capture latency: record fields and rec_valid_o registered, visible cycle after the pulse.
//  - Every asserted err_valid_i bit not captured in that cycle increments lost_cnt by one
//    (popcount, multiple per cycle); sum saturates at all-ones, never wraps.
//  - In HELD, record fields frozen; all incoming pulses count as lost.
//  - clear_i in HELD with no new error: rec_valid_o->0, lost_cnt->0 next cycle; fields keep
//    stale values (SW ignores them when rec_valid_o=0).
//  - clear_i coincident with new error(s): clear takes effect and the arbitrated winner is
//    captured the same cycle (stays HELD, new record); lost_cnt restarts at count of losers.
//  - clear_i in IDLE: no effect.
//  - wsi_o = rec_valid_o & intr_en_i, derived from flops only (no input-to-output path);
//    toggling intr_en_i while HELD masks/unmasks the level without disturbing the record.
//  - Reset mid-HELD: record, counter, pointer discarded asynchronously.
// STRUCTURE
//  - rv_iopmp_pkg: err_type_t enum (3b), access_t (existing), err_record_t packed struct
//    {inst, etype, ttype, sid, addr}; add ERR_LOST_CNT_W constant.
//  - One sub-module: rv_iopmp_rr_arbiter (request vector + pointer -> one-hot grant, index);
//    popcount and FSM stay in this file. Regmap owns register decode and clear_i generation.
// TESTING
//  - Single error inst0 addr=0x8000_0000 sid=1 etype=1 -> rec_valid_o=1 next cycle, fields match,
//    lost_cnt_o=0, wsi_o=1 with intr_en_i=1.
//  - intr_en_i=0 then error -> rec_valid_o=1, wsi_o=0; raise intr_en_i -> wsi_o=1 same cycle after.
//  - HELD, 3 further pulses -> lost_cnt_o=3, record unchanged; clear_i -> rec_valid_o=0,
//    lost_cnt_o=0, wsi_o=0.
//  - N=4, err_valid_i=4'b1111 twice with clear between -> first rec_inst_o=0, lost=3;
//    second rec_inst_o=1 (round-robin), lost=3.
//  - clear_i and err_valid_i[2] same cycle (N=4) -> rec_inst_o=2, rec_valid_o stays 1, lost_cnt_o=0.
//  - LOST_CNT_WIDTH=2: 5 dropped pulses -> lost_cnt_o=3 (saturated); assert rst_ni low mid-HELD ->
//    all outputs 0 immediately.

Source files
------------

// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access and error-type encodings, plus width helpers for the error-record path.
package rv_iopmp_pkg;

  localparam int ERR_LOST_CNT_W = 8;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'd0,
    ACCESS_READ  = 2'd1,
    ACCESS_WRITE = 2'd2,
    ACCESS_EXEC  = 2'd3
  } access_t;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_ILLEGAL_READ  = 3'd1,
    ERR_ILLEGAL_WRITE = 3'd2,
    ERR_ILLEGAL_FETCH = 3'd3,
    ERR_PARTIAL_HIT   = 3'd4,
    ERR_NO_HIT        = 3'd5,
    ERR_UNKNOWN_SID   = 3'd6,
    ERR_RSVD          = 3'd7
  } err_type_t;

  // Instance-index width; a single instance still needs one bit.
  function automatic int inst_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i, wrapping to index 0.
module rv_iopmp_rr_arbiter #(
  parameter int N     = 1,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic found;

  // Upper pass covers [ptr, N-1]; lower pass picks up the wrapped requests.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error-record stage: arbitrates violation pulses, holds one record until SW clears it,
// counts dropped violations (saturating) and drives the wired interrupt level.
module rv_iopmp_err_capture
  import rv_iopmp_pkg::*;
#(
  parameter int NUMBER_TL_INSTANCES = 1,
  parameter int ADDR_WIDTH          = 64,
  parameter int SID_WIDTH           = 1,
  parameter int LOST_CNT_WIDTH      = ERR_LOST_CNT_W
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NUMBER_TL_INSTANCES-1:0]          err_valid_i,
  input  logic [NUMBER_TL_INSTANCES*ADDR_WIDTH-1:0] err_addr_i,
  input  logic [NUMBER_TL_INSTANCES*SID_WIDTH-1:0]  err_sid_i,
  input  logic [NUMBER_TL_INSTANCES*2-1:0]        err_ttype_i,
  input  logic [NUMBER_TL_INSTANCES*3-1:0]        err_etype_i,
  input  logic                                    intr_en_i,
  input  logic                                    clear_i,
  output logic                                    rec_valid_o,
  output logic [ADDR_WIDTH-1:0]                   rec_addr_o,
  output logic [SID_WIDTH-1:0]                    rec_sid_o,
  output logic [1:0]                              rec_ttype_o,
  output logic [2:0]                              rec_etype_o,
  output logic [inst_w(NUMBER_TL_INSTANCES)-1:0]  rec_inst_o,
  output logic [LOST_CNT_WIDTH-1:0]               lost_cnt_o,
  output logic                                    wsi_o
);

  localparam int N      = NUMBER_TL_INSTANCES;
  localparam int INST_W = inst_w(N);
  localparam int CW     = $clog2(N + 1);
  localparam int SW     = LOST_CNT_WIDTH + CW;

  typedef enum logic {IDLE, HELD} state_e;

  typedef struct packed {
    logic [INST_W-1:0]     inst;
    err_type_t             etype;
    access_t               ttype;
    logic [SID_WIDTH-1:0]  sid;
    logic [ADDR_WIDTH-1:0] addr;
  } err_record_t;

  state_e                    state_q, state_d;
  err_record_t               rec_q, rec_d;
  logic [INST_W-1:0]         ptr_q, ptr_d;
  logic [LOST_CNT_WIDTH-1:0] lost_q, lost_d, lost_base;
  logic                      wsi_q;

  logic [N-1:0]              grant;
  logic [INST_W-1:0]         win_idx;
  logic                      any_err, capture;
  logic [CW-1:0]             err_count, loser_count;
  logic [SW-1:0]             lost_sum;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [SID_WIDTH-1:0]      sel_sid;
  logic [1:0]                sel_ttype;
  logic [2:0]                sel_etype;

  rv_iopmp_rr_arbiter #(
    .N     (N),
    .IDX_W (INST_W)
  ) u_arb (
    .req_i   (err_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (grant),
    .idx_o   (win_idx),
    .valid_o (any_err)
  );

  // One-hot grant steers the winner's payload; popcount gives total pulses this cycle.
  always_comb begin
    sel_addr  = '0;
    sel_sid   = '0;
    sel_ttype = '0;
    sel_etype = '0;
    err_count = '0;
    for (int i = 0; i < N; i++) begin
      err_count = err_count + CW'(err_valid_i[i]);
      if (grant[i]) begin
        sel_addr  = err_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_sid   = err_sid_i[i*SID_WIDTH +: SID_WIDTH];
        sel_ttype = err_ttype_i[i*2 +: 2];
        sel_etype = err_etype_i[i*3 +: 3];
      end
    end
  end

  // A clear frees the slot in the same cycle, so a coincident error is captured immediately.
  always_comb begin
    state_d   = state_q;
    rec_d     = rec_q;
    ptr_d     = ptr_q;
    lost_base = lost_q;
    capture   = any_err && ((state_q == IDLE) || clear_i);
    if ((state_q == HELD) && clear_i) begin
      state_d   = IDLE;
      lost_base = '0;
    end
    if (capture) begin
      state_d   = HELD;
      lost_base = '0;
      rec_d     = '{inst:  win_idx,
                    etype: err_type_t'(sel_etype),
                    ttype: access_t'(sel_ttype),
                    sid:   sel_sid,
                    addr:  sel_addr};
      ptr_d     = (win_idx == INST_W'(N - 1)) ? '0 : win_idx + INST_W'(1);
    end
    loser_count = err_count - CW'(capture);
    lost_sum    = SW'(lost_base) + SW'(loser_count);
    lost_d      = (lost_sum > SW'({LOST_CNT_WIDTH{1'b1}})) ? '1 : lost_sum[LOST_CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rec_q   <= '0;
      ptr_q   <= '0;
      lost_q  <= '0;
      wsi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      ptr_q   <= ptr_d;
      lost_q  <= lost_d;
      wsi_q   <= (state_d == HELD) && intr_en_i;
    end
  end

  assign rec_valid_o = (state_q == HELD);
  assign rec_addr_o  = rec_q.addr;
  assign rec_sid_o   = rec_q.sid;
  assign rec_ttype_o = rec_q.ttype;
  assign rec_etype_o = rec_q.etype;
  assign rec_inst_o  = rec_q.inst;
  assign lost_cnt_o  = lost_q;
  assign wsi_o       = wsi_q;

endmodule
